// File: rtl/conv_tile_sequencer.sv
// Byte-stream front/back end for the 3x3 row-stationary PE array: loads filter and
// ifmap buffers, sequences the array reset/enable window, then streams out the results.
module conv_tile_sequencer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned FLT_N          = 9,
    parameter int unsigned IF_N           = 25,
    parameter int unsigned OUT_N          = 9,
    parameter int unsigned COMPUTE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    output logic [FLT_N*DATA_W-1:0]   filter_flat,
    output logic [IF_N*DATA_W-1:0]    ifmap_flat,
    output logic                      arr_rst,
    output logic                      arr_en,
    input  logic [OUT_N*DATA_W-1:0]   sum_in_flat,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    output logic                      busy
);
    localparam int unsigned MAX_A = (FLT_N > OUT_N) ? FLT_N : OUT_N;
    localparam int unsigned MAX_N = (IF_N > MAX_A) ? IF_N : MAX_A;
    localparam int unsigned IDX_W = $clog2(MAX_N + 1);
    localparam int unsigned CYC_W = $clog2(COMPUTE_CYCLES + 1);

    typedef enum logic [2:0] {LOAD_FLT, LOAD_IF, ARR_RST, COMPUTE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CYC_W-1:0]          cyc_q, cyc_d;
    logic [FLT_N*DATA_W-1:0]   filter_q;
    logic [IF_N*DATA_W-1:0]    ifmap_q;
    logic [OUT_N*DATA_W-1:0]   result_q;
    logic                      capture;
    logic                      s_fire, m_fire;

    assign s_ready = !rst && (state_q == LOAD_FLT || state_q == LOAD_IF);
    assign s_fire  = s_valid && s_ready;
    assign m_valid = (state_q == DRAIN);
    assign m_fire  = m_valid && m_ready;
    assign arr_en  = (state_q == COMPUTE);
    assign arr_rst = !arr_en;
    assign busy    = (state_q == ARR_RST) || (state_q == COMPUTE) || (state_q == DRAIN);
    assign m_last  = m_valid && (idx_q == IDX_W'(OUT_N - 1));

    assign filter_flat = filter_q;
    assign ifmap_flat  = ifmap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_FLT;
            idx_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        capture = 1'b0;
        case (state_q)
            LOAD_FLT: if (s_fire) begin
                if (idx_q == IDX_W'(FLT_N - 1)) begin
                    idx_d   = '0;
                    state_d = LOAD_IF;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LOAD_IF: if (s_fire) begin
                if (idx_q == IDX_W'(IF_N - 1)) begin
                    idx_d   = '0;
                    state_d = ARR_RST;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ARR_RST: begin
                cyc_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (cyc_q == CYC_W'(COMPUTE_CYCLES - 1)) begin
                    capture = 1'b1;
                    cyc_d   = '0;
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DRAIN: if (m_fire) begin
                if (idx_q == IDX_W'(OUT_N - 1)) begin
                    idx_d   = '0;
                    state_d = LOAD_FLT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = LOAD_FLT;
        endcase
    end

    // Buffers update only on handshakes / the capture edge; old tile data persists otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            filter_q <= '0;
            ifmap_q  <= '0;
            result_q <= '0;
        end else begin
            if (s_fire && state_q == LOAD_FLT) begin
                for (int k = 0; k < int'(FLT_N); k++)
                    if (idx_q == IDX_W'(k)) filter_q[k*DATA_W +: DATA_W] <= s_data;
            end
            if (s_fire && state_q == LOAD_IF) begin
                for (int k = 0; k < int'(IF_N); k++)
                    if (idx_q == IDX_W'(k)) ifmap_q[k*DATA_W +: DATA_W] <= s_data;
            end
            if (capture) result_q <= sum_in_flat;
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < int'(OUT_N); k++)
            if (idx_q == IDX_W'(k)) m_data = result_q[k*DATA_W +: DATA_W];
    end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: directed tiles with literal expectations, then random
// traffic checked each cycle against a byte-count/cycle-count reference model.
module tb_conv_tile_sequencer;
    localparam int DW = 8, FN = 9, IN = 25, ON = 9, CC = 8;
    localparam int LOAD_N = FN + IN;

    logic                 clk, rst;
    logic                 s_valid, s_ready;
    logic [DW-1:0]        s_data;
    logic [FN*DW-1:0]     filter_flat;
    logic [IN*DW-1:0]     ifmap_flat;
    logic                 arr_rst, arr_en;
    logic [ON*DW-1:0]     sum_in_flat;
    logic                 m_valid, m_ready, m_last, busy;
    logic [DW-1:0]        m_data;

    conv_tile_sequencer #(.DATA_W(DW), .FLT_N(FN), .IF_N(IN), .OUT_N(ON), .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .filter_flat(filter_flat), .ifmap_flat(ifmap_flat), .arr_rst(arr_rst), .arr_en(arr_en),
        .sum_in_flat(sum_in_flat), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: bytes accepted this tile, cycles since load finished, drain position.
    logic [DW-1:0] mf [FN];
    logic [DW-1:0] mi [IN];
    logic [DW-1:0] mres [ON];
    int n_in, t, d;

    logic [DW-1:0] acc_q[$];
    int en_cnt, last_cnt;
    logic [DW-1:0] last_val;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mf[k]) mf[k] = '0;
        foreach (mi[k]) mi[k] = '0;
        foreach (mres[k]) mres[k] = '0;
        n_in = 0; t = 0; d = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit r, input bit sv, input logic [DW-1:0] sd,
                        input bit mr, input logic [ON*DW-1:0] sm);
        logic [FN*DW-1:0] ef;
        logic [IN*DW-1:0] ei;
        bit loading, exp_busy, exp_en, exp_mv;
        @(negedge clk);
        rst = r; s_valid = sv; s_data = sd; m_ready = mr; sum_in_flat = sm;
        #1;
        foreach (mf[k]) ef[k*DW +: DW] = mf[k];
        foreach (mi[k]) ei[k*DW +: DW] = mi[k];
        loading  = (n_in < LOAD_N);
        exp_busy = !loading;
        exp_en   = exp_busy && t >= 1 && t <= CC;
        exp_mv   = exp_busy && t > CC;
        chk("s_ready", s_ready, !r && loading);
        chk("busy", busy, exp_busy);
        chk("arr_en", arr_en, exp_en);
        chk("arr_rst", arr_rst, !exp_en);
        chk("m_valid", m_valid, exp_mv);
        chk("filter_flat", filter_flat, ef);
        chk("ifmap_flat", ifmap_flat, ei);
        if (exp_mv) begin
            chk("m_data", m_data, mres[d]);
            chk("m_last", m_last, d == ON - 1);
        end
        if (m_valid && mr) begin
            acc_q.push_back(m_data);
            if (m_last) begin last_cnt++; last_val = m_data; end
        end
        if (arr_en) en_cnt++;
        if (r) model_reset();
        else if (loading) begin
            if (sv) begin
                if (n_in < FN) mf[n_in] = sd; else mi[n_in - FN] = sd;
                n_in++;
            end
        end else if (t <= CC) begin
            if (t == CC) foreach (mres[k]) mres[k] = sm[k*DW +: DW];
            t++;
        end else if (mr) begin
            if (d == ON - 1) begin n_in = 0; t = 0; d = 0; end
            else d++;
        end
    endtask

    task automatic check_drain_seq(input string nm);
        chk({nm, "_count"}, acc_q.size(), ON);
        for (int k = 0; k < ON && k < acc_q.size(); k++) chk(nm, acc_q[k], k + 1);
        chk({nm, "_last_cnt"}, last_cnt, 1);
        chk({nm, "_last_val"}, last_val, 8'h09);
    endtask

    logic [ON*DW-1:0] pat, ones;
    logic [95:0] rnd;

    initial begin
        pat  = 72'h090807060504030201;
        ones = '1;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; sum_in_flat = '0;
        model_reset();
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("reset_arr_rst", arr_rst, 1'b1);
        chk("reset_filter", filter_flat, 0);

        // Tile 1: back-to-back load, free-running drain.
        for (int k = 0; k < FN; k++) step(0, 1, 8'(k + 1), 1, pat);
        for (int k = 0; k < IN; k++) step(0, 1, 8'(k), 1, pat);
        en_cnt = 0;
        step(0, 0, 0, 1, pat);
        chk("t1_arr_rst_cycle", {arr_rst, arr_en}, 2'b10);
        chk("t1_flt0", filter_flat[7:0], 8'h01);
        chk("t1_flt8", filter_flat[71:64], 8'h09);
        chk("t1_if24", ifmap_flat[199:192], 8'h18);
        for (int k = 0; k < CC; k++) begin
            step(0, 0, 0, 1, pat);
            chk("t1_busy", busy, 1'b1);
        end
        chk("t1_en_cycles", en_cnt, CC);
        acc_q.delete(); last_cnt = 0;
        for (int k = 0; k < ON; k++) step(0, 0, 0, 1, ones);
        check_drain_seq("t1_drain");
        step(0, 0, 0, 1, ones);
        chk("t1_back_to_load", s_ready, 1'b1);

        // Tile 2: toggled s_valid, 0x55 held while not loading, stalled drain.
        for (int k = 0; k < FN; k++) begin
            step(0, 1, 8'(k + 1), 1, pat);
            step(0, 0, 8'hEE, 1, pat);
        end
        chk("t2_filter", filter_flat, 72'h090807060504030201);
        for (int k = 0; k < IN; k++) step(0, 1, 8'(k), 1, pat);
        for (int k = 0; k < CC + 1; k++) begin
            step(0, 1, 8'h55, 1, pat);
            chk("t2_sready_busy", s_ready, 1'b0);
        end
        acc_q.delete(); last_cnt = 0;
        for (int k = 0; k < 3; k++) step(0, 1, 8'h55, 1, ones);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 8'h55, 0, ones);
            chk("t2_stall_data", m_data, 8'h04);
            chk("t2_stall_last", m_last, 1'b0);
        end
        step(0, 1, 8'h55, 1, ones);
        step(0, 1, 8'h55, 1, ones);
        chk("t2_after_stall", acc_q[acc_q.size()-1], 8'h05);
        for (int k = 0; k < 4; k++) step(0, 1, 8'h55, 1, ones);
        check_drain_seq("t2_drain");
        chk("t2_if24_held", ifmap_flat[199:192], 8'h18);

        // Mid-load reset.
        for (int k = 0; k < FN + 10; k++) step(0, 1, 8'(k + 8'h30), 1, pat);
        step(1, 1, 8'h77, 1, pat);
        step(0, 0, 0, 1, pat);
        chk("rst_filter", filter_flat, 0);
        chk("rst_ifmap", ifmap_flat, 0);
        chk("rst_arr_rst", arr_rst, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        step(0, 1, 8'hAA, 1, pat);
        step(0, 0, 0, 1, pat);
        chk("rst_first_byte", filter_flat[7:0], 8'hAA);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 2) != 0, rnd[ON*DW-1:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
